mem_lsu: RTL and testbench

Load/store unit of the MEM stage. It reads the instruction held in the EX/MEM pipeline register: destination register, write-enable, ALU result (the effective address for memory ops), store data and access type. It performs the access on a single-outstanding valid/ready data bus, stalling the pipeline until the response returns, and presents the final rd/wreg/wdata triple to the MEM/WB register. Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/mem_lsu.sv | 172 +++++++++++++++++
 tb/tb_mem_lsu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-outstanding valid/ready data bus access,
// load formatting and pass-through of non-memory results to MEM/WB.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_i,
  input  logic        wreg_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] store_data_i,
  input  logic [1:0]  mem_op_i,
  input  logic [2:0]  funct3_i,
  input  logic        hold_i,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_rdata,
  output logic [4:0]  rd_addr_o,
  output logic        wreg_o,
  output logic [63:0] wdata_o,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        issue;
  logic        is_load, is_store, is_mem, misaligned;
  logic [2:0]  off;
  logic [63:0] st_wdata;
  logic [7:0]  st_strb;
  logic [63:0] lane, load_fmt;

  // Latched request fields, stable for the whole access.
  logic        req_we_q;
  logic [63:0] req_addr_q;
  logic [63:0] req_wdata_q;
  logic [7:0]  req_wstrb_q;
  logic [2:0]  off_q;
  logic [2:0]  funct3_q;
  logic        load_q;
  logic [63:0] result_q;

  assign is_load  = (mem_op_i == 2'd1);
  assign is_store = (mem_op_i == 2'd2);
  assign is_mem   = is_load | is_store;
  assign off      = wdata_i[2:0];

  // Alignment check and store lane replication/strobes by access width.
  always_comb begin
    misaligned = 1'b0;
    st_wdata   = store_data_i;
    st_strb    = 8'hFF;
    case (funct3_i[1:0])
      2'd0: begin
        misaligned = 1'b0;
        st_wdata   = {8{store_data_i[7:0]}};
        st_strb    = 8'h01;
      end
      2'd1: begin
        misaligned = off[0];
        st_wdata   = {4{store_data_i[15:0]}};
        st_strb    = 8'h03;
      end
      2'd2: begin
        misaligned = |off[1:0];
        st_wdata   = {2{store_data_i[31:0]}};
        st_strb    = 8'h0F;
      end
      default: begin
        misaligned = |off;
        st_wdata   = store_data_i;
        st_strb    = 8'hFF;
      end
    endcase
  end

  // Extract the addressed lane from the response and sign/zero-extend it.
  always_comb begin
    lane = rsp_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_fmt = {{56{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_fmt = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_fmt = {56'd0, lane[7:0]};
      3'b101:  load_fmt = {48'd0, lane[15:0]};
      3'b110:  load_fmt = {32'd0, lane[31:0]};
      default: load_fmt = lane;
    endcase
  end

  // Next-state and MEM/WB outputs; stalled cycles never write back.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    rd_addr_o  = rd_addr_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (is_mem) begin
          wreg_o = 1'b0;
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            issue   = 1'b1;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        stall_o = 1'b1;
        wreg_o  = 1'b0;
        if (req_ready) state_d = StWait;
      end
      StWait: begin
        stall_o = 1'b1;
        wreg_o  = 1'b0;
        if (rsp_valid) state_d = StDone;
      end
      StDone: begin
        wreg_o  = load_q & wreg_i;
        wdata_o = result_q;
        // Holding here keeps a frozen EX/MEM from re-issuing the access.
        if (!hold_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latched request and captured load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_we_q    <= 1'b0;
      req_addr_q  <= 64'd0;
      req_wdata_q <= 64'd0;
      req_wstrb_q <= 8'd0;
      off_q       <= 3'd0;
      funct3_q    <= 3'd0;
      load_q      <= 1'b0;
      result_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        req_we_q    <= is_store;
        req_addr_q  <= {wdata_i[63:3], 3'b000};
        req_wdata_q <= st_wdata;
        req_wstrb_q <= is_store ? (st_strb << off) : 8'd0;
        off_q       <= off;
        funct3_q    <= funct3_i;
        load_q      <= is_load;
      end
      if ((state_q == StWait) && rsp_valid) result_q <= load_fmt;
    end
  end

  // Bus request is driven purely from registered state.
  assign req_valid = (state_q == StReq);
  assign req_we    = req_valid & req_we_q;
  assign req_wstrb = req_valid ? req_wstrb_q : 8'd0;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized accesses
// compared against a byte-level reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_i;
  logic        wreg_i;
  logic [63:0] wdata_i;
  logic [63:0] store_data_i;
  logic [1:0]  mem_op_i;
  logic [2:0]  funct3_i;
  logic        hold_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic [4:0]  rd_addr_o;
  logic        wreg_o;
  logic [63:0] wdata_o;
  logic        stall_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  mem_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_i    (rd_addr_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .store_data_i (store_data_i),
    .mem_op_i     (mem_op_i),
    .funct3_i     (funct3_i),
    .hold_i       (hold_i),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rd_addr_o    (rd_addr_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stall_o      (stall_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_misaligned(input logic [63:0] addr, input logic [2:0] f3);
    return (addr[2:0] % acc_bytes(f3)) != 0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input logic [2:0] f3);
    int n = acc_bytes(f3);
    int o = int'(addr[2:0]);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = rdata[8*(o+i) +: 8];
    if (!f3[2] && n < 8 && r[8*n-1])
      for (int j = n; j < 8; j++) r[8*j +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [63:0] addr, input logic [2:0] f3);
    int n = acc_bytes(f3);
    int o = int'(addr[2:0]);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 8; i++) s[i] = (i >= o) && (i < o + n);
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] d, input logic [2:0] f3);
    int n = acc_bytes(f3);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic run_nonmem(input logic [4:0] rd, input logic we, input logic [63:0] val,
                            input logic [1:0] op);
    rd_addr_i = rd; wreg_i = we; wdata_i = val; mem_op_i = op;
    funct3_i = 3'($urandom); store_data_i = {$urandom, $urandom}; hold_i = 1'b0;
    #1;
    chk("nm_wdata", wdata_o, val);
    chk("nm_rd", 64'(rd_addr_o), 64'(rd));
    chk("nm_wreg", 64'(wreg_o), 64'(we));
    chk("nm_stall", 64'(stall_o), 64'd0);
    chk("nm_misalign", 64'(misalign_o), 64'd0);
    chk("nm_reqv", 64'(req_valid), 64'd0);
    @(posedge clk); #1;
    chk("nm_reqv_next", 64'(req_valid), 64'd0);
  endtask

  task automatic run_misalign(input logic [4:0] rd, input logic [63:0] addr,
                              input logic [1:0] op, input logic [2:0] f3);
    rd_addr_i = rd; wreg_i = 1'b1; wdata_i = addr; mem_op_i = op; funct3_i = f3;
    store_data_i = {$urandom, $urandom}; hold_i = 1'b0;
    #1;
    chk("mis_flag", 64'(misalign_o), 64'd1);
    chk("mis_wreg", 64'(wreg_o), 64'd0);
    chk("mis_stall", 64'(stall_o), 64'd0);
    chk("mis_reqv", 64'(req_valid), 64'd0);
    @(posedge clk); #1;
    chk("mis_reqv_next", 64'(req_valid), 64'd0);
  endtask

  task automatic run_mem(input logic [4:0] rd, input logic we, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [1:0] op, input logic [2:0] f3,
                         input logic [63:0] rdata, input int rdly, input int sdly,
                         input int hold);
    int stalls = 0, nvalid = 0, acc = 0, rw = 0;
    bit done = 0;
    bit is_st = (op == 2'd2);
    logic [63:0] exp_res = ref_load(rdata, addr, f3);
    rd_addr_i = rd; wreg_i = we; wdata_i = addr; store_data_i = sdata;
    mem_op_i = op; funct3_i = f3; hold_i = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0;
    #1;
    chk("idle_stall", 64'(stall_o), 64'd1);
    chk("idle_misalign", 64'(misalign_o), 64'd0);
    chk("idle_reqv", 64'(req_valid), 64'd0);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (!stall_o) begin
        done = 1;
      end else begin
        stalls++;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = {$urandom, $urandom};
        if (req_valid) begin
          nvalid++;
          chk("req_addr", req_addr, {addr[63:3], 3'b000});
          chk("req_we", 64'(req_we), 64'(is_st));
          chk("req_wstrb", 64'(req_wstrb), is_st ? 64'(ref_strb(addr, f3)) : 64'd0);
          if (is_st) chk("req_wdata", req_wdata, ref_wdata(sdata, f3));
          req_ready = (nvalid > rdly);
          rsp_valid = 1'($urandom_range(0, 1));  // must be ignored in REQ
          if (req_ready) acc++;
        end else if (acc > 0) begin
          req_ready = 1'($urandom_range(0, 1));  // must be ignored in WAIT
          if (rw >= sdly) begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata;
          end
          rw++;
        end
        @(posedge clk); #1;
        req_ready = 1'b0; rsp_valid = 1'b0;
        #1;
      end
    end
    chk("done_reached", 64'(done), 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(3 + rdly + sdly));
    chk("req_valid_cycles", 64'(nvalid), 64'(rdly + 1));
    for (int k = 0; k <= hold; k++) begin
      hold_i = (k < hold);
      rsp_valid = 1'b1; rsp_rdata = {$urandom, $urandom}; req_ready = 1'b1;
      chk("done_stall", 64'(stall_o), 64'd0);
      chk("done_reqv", 64'(req_valid), 64'd0);
      chk("done_rd", 64'(rd_addr_o), 64'(rd));
      chk("done_wreg", 64'(wreg_o), is_st ? 64'd0 : 64'(we));
      if (!is_st) chk("done_wdata", wdata_o, exp_res);
      @(posedge clk); #1;
      rsp_valid = 1'b0; req_ready = 1'b0;
      if (k < hold) #1;
    end
    mem_op_i = 2'd0; hold_i = 1'b0; wdata_i = 64'd0;
    #1;
    chk("after_reqv", 64'(req_valid), 64'd0);
    chk("after_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    chk("after_reqv_next", 64'(req_valid), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] addr,
                        input int rdly, input int sdly, input int hold);
    logic [4:0] rd = 5'($urandom);
    logic we = 1'($urandom);
    if (op == 2'd1 || op == 2'd2) begin
      if (ref_misaligned(addr, f3)) run_misalign(rd, addr, op, f3);
      else run_mem(rd, we, addr, {$urandom, $urandom}, op, f3, {$urandom, $urandom},
                   rdly, sdly, hold);
    end else begin
      run_nonmem(rd, we, addr, op);
    end
  endtask

  initial begin
    rst = 1'b0; rd_addr_i = '0; wreg_i = 1'b0; wdata_i = '0; store_data_i = '0;
    mem_op_i = '0; funct3_i = '0; hold_i = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    rsp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reqv", 64'(req_valid), 64'd0);
    chk("rst_we", 64'(req_we), 64'd0);
    chk("rst_wstrb", 64'(req_wstrb), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_misalign", 64'(misalign_o), 64'd0);
    chk("rst_wreg", 64'(wreg_o), 64'd0);
    chk("rst_rd", 64'(rd_addr_o), 64'd0);
    chk("rst_wdata", wdata_o, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // ADD pass-through, reserved op treated as none
    run_nonmem(5'd5, 1'b1, 64'h1234, 2'd0);
    run_nonmem(5'd9, 1'b1, 64'hCAFE_0000_1111_2222, 2'd3);
    // LB sign-extended, zero-wait bus
    run_mem(5'd7, 1'b1, 64'h1003, 64'd0, 2'd1, 3'b000, 64'h0000_0000_8000_0000, 0, 0, 0);
    // LWU with req_ready low two cycles
    run_mem(5'd8, 1'b1, 64'h2004, 64'd0, 2'd1, 3'b110, 64'hDEAD_BEEF_0000_0001, 2, 0, 0);
    // SH upper lane
    run_mem(5'd4, 1'b1, 64'h3006, 64'hABCD, 2'd2, 3'b001, 64'd0, 0, 1, 0);
    // LW misaligned
    run_misalign(5'd6, 64'h4002, 2'd1, 3'b010);
    // LD held in DONE two cycles
    run_mem(5'd10, 1'b1, 64'h5008, 64'd0, 2'd1, 3'b011, 64'h0123_4567_89AB_CDEF, 0, 0, 2);

    // Reset while waiting for the response
    rd_addr_i = 5'd11; wreg_i = 1'b1; wdata_i = 64'h6010; mem_op_i = 2'd1; funct3_i = 3'b011;
    @(posedge clk); #1;
    chk("rw_reqv", 64'(req_valid), 64'd1);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    chk("rw_wait_stall", 64'(stall_o), 64'd1);
    rst = 1'b0;
    rd_addr_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_op_i = '0; funct3_i = '0;
    #1;
    chk("rw_rst_reqv", 64'(req_valid), 64'd0);
    chk("rw_rst_stall", 64'(stall_o), 64'd0);
    chk("rw_rst_we", 64'(req_we), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rd_addr_i = 5'd3; wreg_i = 1'b1; wdata_i = 64'h77;
    rsp_valid = 1'b1; rsp_rdata = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rw_late_stall", 64'(stall_o), 64'd0);
      chk("rw_late_wdata", wdata_o, 64'h77);
      chk("rw_late_reqv", 64'(req_valid), 64'd0);
      @(posedge clk); #1;
    end
    rsp_valid = 1'b0;
    run_mem(5'd12, 1'b1, 64'h7000, 64'd0, 2'd1, 3'b001, 64'h0000_0000_0000_8001, 1, 1, 0);

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  op = 2'($urandom_range(0, 3));
      logic [2:0]  f3;
      logic [63:0] addr = {$urandom, $urandom};
      if (op == 2'd2) f3 = 3'($urandom_range(0, 3));
      else f3 = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(acc_bytes(f3) - 1));
      run_op(op, f3, addr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
